// File: rtl/if_id_stall_ctrl_pkg.sv
// IF/ID stall controller shared types.
// NOP encoding and controller state codes.
package if_id_stall_ctrl_pkg;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/if_id_stall_ctrl_if.sv
// Fetch/decode side bundle of the IF/ID stall controller.
// slave = controller, master = surrounding pipeline.
interface if_id_stall_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int CNT_W = 16
);
    logic             hazard;
    logic             flush;
    logic [15:0]      instr_in;
    logic [PC_W-1:0]  pc_in;
    logic             pc_we;
    logic [15:0]      if_id_instr;
    logic [PC_W-1:0]  if_id_pc;
    logic             if_id_valid;
    logic             id_ex_bubble;
    logic             stall_active;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport slave (
        input  hazard, flush, instr_in, pc_in,
        output pc_we, if_id_instr, if_id_pc, if_id_valid,
        output id_ex_bubble, stall_active, stall_cycles, flush_count
    );

    modport master (
        output hazard, flush, instr_in, pc_in,
        input  pc_we, if_id_instr, if_id_pc, if_id_valid,
        input  id_ex_bubble, stall_active, stall_cycles, flush_count
    );
endinterface

// File: rtl/if_id_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module if_id_stall_ctrl_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, stick at all-ones, clear wins.
    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/if_id_stall_ctrl.sv
// IF/ID register owner: load-use stalls, flush squash, replay buffer.
// STALL_PERF_EN adds saturating stall/flush counters.
import if_id_stall_ctrl_pkg::*;

module if_id_stall_ctrl #(
    parameter int PC_W         = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic               clk,
    input logic               rst,
    if_id_stall_ctrl_if.slave bus
);

    localparam int FC_W =
        (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

    state_t          state;
    logic [15:0]     instr_q;
    logic [PC_W-1:0] pc_q;
    logic            valid_q;
    logic [15:0]     buf_instr;
    logic [PC_W-1:0] buf_pc;
    logic            buf_v;
    logic [FC_W-1:0] fcnt;
    logic            hz;
    logic            pc_we;
    logic            bubble;

    assign hz = bus.hazard & valid_q;

    assign bus.pc_we        = pc_we;
    assign bus.id_ex_bubble = bubble;
    assign bus.if_id_instr  = instr_q;
    assign bus.if_id_pc     = pc_q;
    assign bus.if_id_valid  = valid_q;
    assign bus.stall_active = (state == ST_STALL);

    // PC enable and ID/EX bubble: rst > flush > flush window > hazard.
    always_comb begin
        pc_we  = 1'b1;
        bubble = 1'b0;
        if (rst) begin
            pc_we  = 1'b0;
            bubble = 1'b1;
        end else if (bus.flush || (state == ST_FLUSH)) begin
            pc_we  = 1'b1;
            bubble = 1'b1;
        end else if (hz) begin
            pc_we  = 1'b0;
            bubble = 1'b1;
        end
    end

    // Controller FSM with IF/ID register and one-entry replay buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            instr_q   <= NOP_INSTR;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            buf_instr <= NOP_INSTR;
            buf_pc    <= '0;
            buf_v     <= 1'b0;
            fcnt      <= '0;
        end else if (bus.flush) begin
            state   <= ST_FLUSH;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
            buf_v   <= 1'b0;
            fcnt    <= FC_W'(FLUSH_CYCLES);
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (hz) begin
                        buf_instr <= bus.instr_in;
                        buf_pc    <= bus.pc_in;
                        buf_v     <= 1'b1;
                        state     <= ST_STALL;
                    end else begin
                        instr_q <= bus.instr_in;
                        pc_q    <= bus.pc_in;
                        valid_q <= 1'b1;
                    end
                end
                ST_STALL: begin
                    if (!hz) begin
                        instr_q <= buf_instr;
                        pc_q    <= buf_pc;
                        valid_q <= buf_v;
                        buf_v   <= 1'b0;
                        state   <= ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    fcnt <= fcnt - FC_W'(1);
                    if (fcnt <= FC_W'(1))
                        state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef STALL_PERF_EN
    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    assign stall_inc = !rst && !bus.flush && (state != ST_FLUSH) && hz;
    assign flush_inc = !rst && bus.flush;

    if_id_stall_ctrl_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    if_id_stall_ctrl_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_count  = flush_cnt;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_count  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_id_stall_ctrl.sv
// Directed bench for if_id_stall_ctrl with a registered-read IMEM model.
// Covers reset, single/multi-cycle stall, flush in stall, flush+hazard, reset mid-stall.
module tb_if_id_stall_ctrl;

`ifdef STALL_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] imem [64];
    logic [15:0] pc;
    logic [15:0] target;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    if_id_stall_ctrl_if #(.PC_W(16), .CNT_W(16)) bus ();

    if_id_stall_ctrl #(
        .PC_W         (16),
        .FLUSH_CYCLES (1),
        .CNT_W        (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [15:0] word(input int i);
        return 16'h1000 + 16'(i);
    endfunction

    // Fetch stage: PC register and registered IMEM read.
    always @(posedge clk) begin
        if (rst) begin
            pc           <= 16'd0;
            bus.instr_in <= 16'h0000;
            bus.pc_in    <= 16'd0;
        end else begin
            if (bus.pc_we)
                pc <= bus.flush ? target : pc + 16'd1;
            bus.instr_in <= imem[pc[5:0]];
            bus.pc_in    <= pc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic r, input logic h, input logic f);
        @(negedge clk);
        rst        = r;
        bus.hazard = h;
        bus.flush  = f;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++)
            imem[i] = word(i);
        target     = 16'd0;
        bus.hazard = 1'b0;
        bus.flush  = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_valid", bus.if_id_valid, 0);
        check("rst_instr", bus.if_id_instr, 16'h0000);
        check("rst_pcwe", bus.pc_we, 0);
        check("rst_bubble", bus.id_ex_bubble, 1);
        check("rst_stall_cnt", bus.stall_cycles, 0);
        rst = 1'b0;

        for (int k = 1; k <= 5; k++) begin
            tick(0, 0, 0);
            if (k == 3) begin
                check("pipe_instr", bus.if_id_instr, word(1));
                check("pipe_pc", bus.if_id_pc, 1);
            end
        end

        tick(0, 1, 0);
        check("s1_pcwe", bus.pc_we, 0);
        check("s1_bubble", bus.id_ex_bubble, 1);
        check("s1_hold_a", bus.if_id_instr, word(4));
        tick(0, 0, 0);
        check("s1_stall", bus.stall_active, 1);
        check("s1_rel_pcwe", bus.pc_we, 1);
        check("s1_rel_bubble", bus.id_ex_bubble, 0);
        check("s1_still_a", bus.if_id_instr, word(4));
        check("s1_cnt", bus.stall_cycles, PERF ? 1 : 0);
        tick(0, 0, 0);
        check("s1_b_instr", bus.if_id_instr, word(5));
        check("s1_b_pc", bus.if_id_pc, 5);
        check("s1_b_valid", bus.if_id_valid, 1);
        tick(0, 0, 0);
        check("s1_c_instr", bus.if_id_instr, word(6));
        check("s1_c_pc", bus.if_id_pc, 6);

        tick(0, 1, 0);
        check("s3_bub1", bus.id_ex_bubble, 1);
        tick(0, 1, 0);
        check("s3_bub2", bus.id_ex_bubble, 1);
        check("s3_stall", bus.stall_active, 1);
        tick(0, 1, 0);
        check("s3_bub3", bus.id_ex_bubble, 1);
        check("s3_pcwe", bus.pc_we, 0);
        check("s3_hold", bus.if_id_instr, word(7));
        tick(0, 0, 0);
        check("s3_rel", bus.id_ex_bubble, 0);
        check("s3_rel_hold", bus.if_id_instr, word(7));
        tick(0, 0, 0);
        check("s3_b_instr", bus.if_id_instr, word(8));
        check("s3_b_pc", bus.if_id_pc, 8);
        check("s3_cnt", bus.stall_cycles, PERF ? 4 : 0);
        tick(0, 0, 0);
        check("s3_c_instr", bus.if_id_instr, word(9));

        tick(0, 1, 0);
        target = 16'd40;
        tick(0, 1, 1);
        check("f4_stall", bus.stall_active, 1);
        check("f4_pcwe", bus.pc_we, 1);
        check("f4_bubble", bus.id_ex_bubble, 1);
        tick(0, 0, 0);
        check("f4_valid1", bus.if_id_valid, 0);
        check("f4_nop", bus.if_id_instr, 16'h0000);
        check("f4_nostall", bus.stall_active, 0);
        check("f4_fl_bubble", bus.id_ex_bubble, 1);
        tick(0, 0, 0);
        check("f4_valid2", bus.if_id_valid, 0);
        check("f4_run_bubble", bus.id_ex_bubble, 0);
        tick(0, 0, 0);
        check("f4_tgt_instr", bus.if_id_instr, word(40));
        check("f4_tgt_pc", bus.if_id_pc, 40);
        check("f4_tgt_valid", bus.if_id_valid, 1);
        check("f4_fcnt", bus.flush_count, PERF ? 1 : 0);

        target = 16'd50;
        tick(0, 1, 1);
        check("f5_cur", bus.if_id_instr, word(41));
        check("f5_pcwe", bus.pc_we, 1);
        check("f5_bubble", bus.id_ex_bubble, 1);
        tick(0, 0, 0);
        check("f5_nostall", bus.stall_active, 0);
        check("f5_valid1", bus.if_id_valid, 0);
        tick(0, 0, 0);
        check("f5_valid2", bus.if_id_valid, 0);
        tick(0, 0, 0);
        check("f5_tgt", bus.if_id_instr, word(50));
        check("f5_scnt", bus.stall_cycles, PERF ? 5 : 0);
        check("f5_fcnt", bus.flush_count, PERF ? 2 : 0);

        tick(0, 1, 0);
        check("r6_pre", bus.if_id_instr, word(51));
        tick(1, 1, 0);
        check("r6_stall", bus.stall_active, 1);
        check("r6_pcwe", bus.pc_we, 0);
        check("r6_bubble", bus.id_ex_bubble, 1);
        tick(0, 0, 0);
        check("r6_run", bus.stall_active, 0);
        check("r6_valid", bus.if_id_valid, 0);
        check("r6_scnt", bus.stall_cycles, 0);
        check("r6_fcnt", bus.flush_count, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("r6_w0", bus.if_id_instr, word(0));
        check("r6_w0_pc", bus.if_id_pc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
